// File: rtl/hm_time_if.sv
// Bundle of the timekeeping core's control inputs and display outputs.
// The master side drives sec_carry, mode, selects, keys and mode_idx.
interface hm_time_if;
    logic       sec_carry;
    logic       mode;
    logic       sel_min;
    logic       sel_hour;
    logic       key1;
    logic       key2;
    logic [3:0] mode_idx;
    logic       day_carry;
    logic [6:0] S3;
    logic [6:0] S4;
    logic [6:0] S5;
    logic [6:0] S6;
    logic [6:0] S7;

    modport master (
        output sec_carry, mode, sel_min, sel_hour, key1, key2, mode_idx,
        input  day_carry, S3, S4, S5, S6, S7
    );

    modport slave (
        input  sec_carry, mode, sel_min, sel_hour, key1, key2, mode_idx,
        output day_carry, S3, S4, S5, S6, S7
    );
endinterface

// File: rtl/hm_time_core.sv
// Minutes/hours counter of the digital clock: counts on seconds carry in run mode,
// steps with synchronized push-button edges in set mode, drives five 7-segment digits.
module hm_time_core #(
    parameter int MIN_MOD  = 60,
    parameter int HOUR_MOD = 24
) (
    input  logic        clk_50,
    input  logic        rst,
    hm_time_if.slave    bus
);
    localparam int MW = $clog2(MIN_MOD);
    localparam int HW = $clog2(HOUR_MOD);
    localparam logic [MW-1:0] MIN_MAX  = MW'(MIN_MOD - 1);
    localparam logic [HW-1:0] HOUR_MAX = HW'(HOUR_MOD - 1);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [MW-1:0] minute_q, minute_d;
    logic [HW-1:0] hour_q, hour_d;
    logic [1:0]    key_s1_q, key_s2_q, key_prev_q;
    logic [1:0]    key_fall;
    logic          key1_ev, key2_ev, step_up, step_dn, adj_min, adj_hour;
    logic          min_at_max, hour_at_max, min_carry;

    // Keys are active-low; a press is the synchronized level going 1->0.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            key_prev_q <= 2'b11;
        end else begin
            key_s1_q   <= {bus.key2, bus.key1};
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
        end
    end

    assign key_fall = key_prev_q & ~key_s2_q;
    assign key1_ev  = key_fall[0];
    assign key2_ev  = key_fall[1];
    assign step_up  = key1_ev & ~key2_ev;
    assign step_dn  = key2_ev & ~key1_ev;
    assign adj_min  = bus.sel_min & ~bus.sel_hour;
    assign adj_hour = bus.sel_hour & ~bus.sel_min;

    assign min_at_max  = (minute_q == MIN_MAX);
    assign hour_at_max = (hour_q == HOUR_MAX);
    assign min_carry   = bus.sec_carry & min_at_max;

    always_comb begin
        minute_d = minute_q;
        hour_d   = hour_q;
        if (!bus.mode) begin
            if (bus.sec_carry) begin
                minute_d = min_at_max ? '0 : minute_q + MW'(1);
                if (min_carry)
                    hour_d = hour_at_max ? '0 : hour_q + HW'(1);
            end
        end else if (adj_min) begin
            if (step_up)
                minute_d = min_at_max ? '0 : minute_q + MW'(1);
            else if (step_dn)
                minute_d = (minute_q == '0) ? MIN_MAX : minute_q - MW'(1);
        end else if (adj_hour) begin
            if (step_up)
                hour_d = hour_at_max ? '0 : hour_q + HW'(1);
            else if (step_dn)
                hour_d = (hour_q == '0) ? HOUR_MAX : hour_q - HW'(1);
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            minute_q <= '0;
            hour_q   <= '0;
        end else begin
            minute_q <= minute_d;
            hour_q   <= hour_d;
        end
    end

    assign bus.day_carry = ~bus.mode & min_carry & hour_at_max;

    // Digit order: minute units, minute tens, hour units, hour tens, mode.
    logic [3:0] digit [5];
    logic [6:0] seg_w [5];

    assign digit[0] = 4'(minute_q % MW'(10));
    assign digit[1] = 4'(minute_q / MW'(10));
    assign digit[2] = 4'(hour_q % HW'(10));
    assign digit[3] = 4'(hour_q / HW'(10));
    assign digit[4] = bus.mode_idx;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_seg
            assign seg_w[gi] = seg7(digit[gi]);
        end
    endgenerate

    assign bus.S3 = seg_w[0];
    assign bus.S4 = seg_w[1];
    assign bus.S5 = seg_w[2];
    assign bus.S6 = seg_w[3];
    assign bus.S7 = seg_w[4];
endmodule

// File: tb/tb_hm_time_core.sv
// Scoreboard bench for hm_time_core: a time model pushes expected display words,
// popped and compared against the segment outputs after each transaction.
module tb_hm_time_core;
    logic clk_50 = 1'b0;
    logic rst    = 1'b1;

    hm_time_if bus ();

    hm_time_core #(.MIN_MOD(60), .HOUR_MOD(24)) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        string       tag;
        logic [27:0] disp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_min  = 0;
    int   m_hr   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] disp_of(input int m, input int h);
        return {SEG_TAB[h / 10], SEG_TAB[h % 10], SEG_TAB[m / 10], SEG_TAB[m % 10]};
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag  = tag;
        e.disp = disp_of(m_min, m_hr);
        sb_q.push_back(e);
    endtask

    task automatic check_disp();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, {4'h0, bus.S6, bus.S5, bus.S4, bus.S3}, {4'h0, e.disp});
            $display("txn %s time=%0d:%0d", e.tag, m_hr, m_min);
        end
    endtask

    // n single-cycle sec_carry pulses; day_carry checked during every pulse.
    task automatic advance(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50);
            bus.sec_carry = 1'b1;
            #1;
            check_eq({tag, "_dc"}, {31'd0, bus.day_carry},
                     {31'd0, (!bus.mode && m_min == 59 && m_hr == 23)});
            if (!bus.mode) begin
                if (m_min == 59) begin
                    m_min = 0;
                    m_hr  = (m_hr == 23) ? 0 : m_hr + 1;
                end else begin
                    m_min++;
                end
            end
            @(negedge clk_50);
            bus.sec_carry = 1'b0;
        end
        push_exp(tag);
        check_disp();
    endtask

    task automatic press(input bit p1, input bit p2, input int hold, input string tag);
        @(negedge clk_50);
        bus.key1 = ~p1;
        bus.key2 = ~p2;
        repeat (hold) @(negedge clk_50);
        bus.key1 = 1'b1;
        bus.key2 = 1'b1;
        repeat (4) @(negedge clk_50);
        if (bus.mode && (p1 ^ p2)) begin
            if (bus.sel_min && !bus.sel_hour)
                m_min = p1 ? (m_min + 1) % 60 : (m_min + 59) % 60;
            else if (bus.sel_hour && !bus.sel_min)
                m_hr = p1 ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
        end
        push_exp(tag);
        check_disp();
    endtask

    initial begin
        bus.sec_carry = 1'b0;
        bus.mode      = 1'b0;
        bus.sel_min   = 1'b0;
        bus.sel_hour  = 1'b0;
        bus.key1      = 1'b1;
        bus.key2      = 1'b1;
        bus.mode_idx  = 4'h0;

        #12;
        push_exp("reset");
        check_disp();
        check_eq("reset_dc", {31'd0, bus.day_carry}, 32'd0);
        @(negedge clk_50);
        rst = 1'b0;

        advance(359, "to_0559");
        advance(1, "roll_0600");
        check_eq("s5_six", {25'd0, bus.S5}, {25'd0, 7'b0000010});

        // Asynchronous clear in the middle of a low clock phase.
        @(negedge clk_50);
        #2 rst = 1'b1;
        #1;
        m_min = 0;
        m_hr  = 0;
        push_exp("async_rst");
        check_disp();
        check_eq("async_rst_dc", {31'd0, bus.day_carry}, 32'd0);
        @(negedge clk_50);
        rst = 1'b0;

        advance(1439, "to_2359");
        advance(1, "day_wrap");

        // Set mode: key event lands on the third rising edge after the fall.
        bus.mode    = 1'b1;
        bus.sel_min = 1'b1;
        @(negedge clk_50);
        bus.key1 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk_50);
            #1;
            if (e == 3) m_min = 1;
            push_exp($sformatf("lat_edge%0d", e));
            check_disp();
        end
        @(negedge clk_50);
        bus.key1 = 1'b1;
        repeat (4) @(negedge clk_50);

        press(1'b0, 1'b1, 5, "min_dn");
        press(1'b0, 1'b1, 5, "min_dn_wrap");
        press(1'b1, 1'b0, 5, "min_up_wrap");
        press(1'b0, 1'b1, 5, "min_dn_59");
        press(1'b1, 1'b0, 20, "min_hold");
        press(1'b0, 1'b1, 5, "min_dn_59b");

        bus.sel_min  = 1'b0;
        bus.sel_hour = 1'b1;
        press(1'b0, 1'b1, 5, "hr_dn_wrap");
        check_eq("s6_two", {25'd0, bus.S6}, {25'd0, 7'b0100100});
        check_eq("s5_three", {25'd0, bus.S5}, {25'd0, 7'b0110000});

        advance(10, "set_carry_blk");

        press(1'b1, 1'b1, 5, "both_keys");
        bus.sel_min = 1'b1;
        press(1'b1, 1'b0, 5, "both_sel");
        bus.sel_min  = 1'b0;
        bus.sel_hour = 1'b0;
        press(1'b0, 1'b1, 5, "no_sel");
        bus.sel_hour = 1'b1;
        press(1'b1, 1'b0, 5, "hr_up_wrap");
        press(1'b0, 1'b1, 5, "hr_dn_23");

        // A key edge still in the synchronizer when run mode returns is dropped.
        @(negedge clk_50);
        bus.key1 = 1'b0;
        @(posedge clk_50);
        @(posedge clk_50);
        @(negedge clk_50);
        bus.mode = 1'b0;
        repeat (3) @(negedge clk_50);
        bus.key1 = 1'b1;
        bus.mode = 1'b1;
        repeat (4) @(negedge clk_50);
        push_exp("pend_drop");
        check_disp();

        bus.mode = 1'b0;
        push_exp("mode_keep");
        check_disp();
        advance(1, "run_wrap");

        for (int i = 0; i < 16; i++) begin
            @(negedge clk_50);
            bus.mode_idx = 4'(i);
            #1;
            check_eq($sformatf("s7_%0h", i), {25'd0, bus.S7}, {25'd0, SEG_TAB[i]});
            $display("txn mode_idx=%0h S7=%b", i, bus.S7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hm_time_core.md
Name: hm_time_core

Overview:
- Minutes/hours timekeeping core of the digital clock, with an adjustable minute counter (0–59) and hour counter (0–23).
- Advances on a carry pulse from the seconds stage when in run mode; adjusted with up/down push-buttons in set mode.
- Drives four BCD 7-segment digits (MM, HH) plus one hex mode-indicator digit.
- Sits between the seconds counter and the board displays.

Parameters:
- MIN_MOD, 60, minute modulus.
- HOUR_MOD, 24, hour modulus.

Ports:
- clk_50  in  1  system clock (50 MHz); all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sec_carry  in  1  one-clock pulse from the seconds stage at its 59->00 wrap.
- mode  in  1  0 = run, 1 = set.
- sel_min  in  1  set mode: minute counter selected for adjustment.
- sel_hour  in  1  set mode: hour counter selected for adjustment.
- key1  in  1  increment button, active-low, asynchronous to clk_50.
- key2  in  1  decrement button, active-low, asynchronous to clk_50.
- mode_idx  in  4  value shown on the mode digit.
- day_carry  out  1  combinational pulse at the 23:59 -> 00:00 rollover.
- S3  out  7  minute units segments.
- S4  out  7  minute tens segments.
- S5  out  7  hour units segments.
- S6  out  7  hour tens segments.
- S7  out  7  mode digit segments.

Behaviour:
- Reset (async, rst=1):
  - minute=0, hour=0; key synchronizers and edge registers set to 1 (released).
  - S3–S6 show "0" (7'b1000000); day_carry=0.
- Segment encoding:
  - Active-low (0 = lit); bit0=a … bit6=g.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - S3–S6 use the 0–9 entries only. S7 decodes mode_idx across the full hex range.
- Digit split: tens = value/10, units = value%10. Purely combinational from registers, zero latency.
- Run mode (mode=0):
  - A sec_carry high on a rising edge increments minute.
  - minute 59 -> 0 generates an internal min_carry in the same cycle; that carry increments hour on the same edge.
  - hour 23 -> 0 wraps.
  - day_carry = !mode & sec_carry & minute==59 & hour==23.
  - Keys are ignored in run mode.
- Set mode (mode=1):
  - sec_carry is ignored and day_carry=0.
  - Each key passes through a 2-flop synchronizer. A press event is the synchronized signal going 1->0, detected with one extra register. The counter updates on the 3rd rising edge after the key falls.
  - No debounce in this block; it is done externally.
  - sel_min=1, sel_hour=0:
    - key1 event: minute+1 with 59->0 wrap; no carry into hour.
    - key2 event: minute-1 with 0->59 wrap.
  - sel_hour=1, sel_min=0: same rules for hour, with 23->0 and 0->23 wraps.
  - No adjustment when:
    - sel_min=sel_hour=0, or both are 1;
    - key1 and key2 events occur in the same cycle.
  - Holding a key gives exactly one step; a new step requires release then press.
- Mode change mid-operation: counter values are kept unchanged. A pending key edge is discarded when mode=0.
- Counter registers never hold out-of-range values (minute ≤ 59, hour ≤ 23).
- rst asserted mid-count: state clears immediately (asynchronously); counting resumes on the first sec_carry after release.

Test Plan:
- Reset: pulse rst with minute/hour nonzero -> S3–S6 = 1000000, day_carry=0, immediately without clock.
- Run rollover: preset 05:59, mode=0, one sec_carry pulse -> 06:00; S5=0000010, S4=S3=1000000.
- Day wrap: preset 23:59, sec_carry -> day_carry=1 during the pulse; next state 00:00.
- Minute set: mode=1, sel_min=1, minute=59; key1 pressed/released once -> minute=0, hour unchanged. key2 at minute 0 -> 59.
- Hour set and carry blocking: mode=1, sel_hour=1, hour=0; key2 press -> 23 (S6=0100100, S5=0110000). Ten sec_carry pulses in set mode -> no change.
- Mode digit and conflicts: mode_idx 0..15 -> S7 follows the hex table. key1 and key2 falling in the same cycle -> no change. Both selects high -> no change.
